sat_event_counter: RTL and testbench
====================================

SAT_EVENT_COUNTER -- requirements
Module: sat_event_counter

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of independent channels (1..16).
REQ-002 SHALL provide parameter WIDTH, default 2, counter width per channel (1..16).
REQ-003 SHALL provide parameter MAX, default 2**WIDTH-1, terminal count per channel (1..2**WIDTH-1).
REQ-004 SHALL provide parameter SYNC_STAGES, default 2, synchronizer depth on trig (2..4).
REQ-005 SHALL provide port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL provide port rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL provide port trig  input  NCH  asynchronous event inputs, one per channel.
REQ-008 SHALL provide port en  input  1  global count enable.
REQ-009 SHALL provide port clr  input  NCH  synchronous per-channel clear.
REQ-010 SHALL provide port mode  input  1  0 = saturate at MAX, 1 = wrap MAX->0.
REQ-011 SHALL provide port sel  input  max(1,clog2(NCH))  readout channel select.
REQ-012 SHALL provide port counts  output  NCH*WIDTH  all counters; channel i at bits [i*WIDTH +: WIDTH].
REQ-013 SHALL provide port count_out  output  WIDTH  counter of channel sel.
REQ-014 SHALL provide port sat  output  NCH  channel counter == MAX.
REQ-015 SHALL provide port ovf  output  NCH  sticky: event arrived while counter == MAX.
REQ-016 SHALL provide port any_ovf  output  1  OR of ovf.

Function
REQ-017 Each trig bit SHALL pass through a SYNC_STAGES-flop synchronizer clocked by clk; no logic sampled from trig directly.
REQ-018 An event on channel i SHALL be a rising edge of the last synchronizer stage (last=1, previous-cycle value=0); one event per rising edge regardless of trig high time.
REQ-019 Latency: trig high meeting setup at edge k SHALL update counts at edge k+SYNC_STAGES.
REQ-020 Events while en=0 SHALL be discarded, not queued; synchronizer/edge state SHALL keep running.
REQ-021 Event with count < MAX SHALL increment count by 1 (modulo 2**WIDTH).
REQ-022 Event with count == MAX and mode=0 SHALL hold count at MAX and set ovf[i].
REQ-023 Event with count == MAX and mode=1 SHALL load 0 and set ovf[i].
REQ-024 ovf[i] SHALL stay set until clr[i] or rst.
REQ-025 clr[i] SHALL load count 0 and clear ovf[i] at next edge; clr[i] has priority over a simultaneous event (event lost).
REQ-026 clr SHALL not affect synchronizer or edge-detect state.
REQ-027 Channels SHALL be fully independent; simultaneous events on any subset SHALL all be counted in the same cycle.
REQ-028 mode changes SHALL take effect on the next event; no retroactive change to count.
REQ-029 sat[i] SHALL be combinational from count (count == MAX); any_ovf combinational OR of ovf.
REQ-030 count_out SHALL be combinational mux of counts by sel; sel >= NCH SHALL yield 0.

Reset
REQ-031 rst SHALL asynchronously force all counts=0, ovf=0; hence sat=0, any_ovf=0, count_out=0.
REQ-032 rst SHALL force all synchronizer and edge-detect flops to 1, so a trig already high at release produces no event.
REQ-033 rst asserted mid-operation SHALL discard in-flight synchronized edges; counting resumes from 0 on the first rising edge after release.

Verification
REQ-034 Defaults, mode=0, en=1: 4 pulses on trig[0] -> counts[1:0] 1,2,3,3; sat[0]=1 after 3rd; ovf[0]=1 after 4th; other channels 0.
REQ-035 mode=1: 4 pulses on trig[1] -> 1,2,3,0; ovf[1]=1, any_ovf=1, sat[1]=0 at end.
REQ-036 Single trig rise 1 ns before edge k -> count changes exactly at edge k+2; trig held high 10 cycles -> one increment only.
REQ-037 clr[2] in same cycle as trig[2] event with count=2 -> count 0, ovf[2]=0; simultaneous events on ch0,ch3 -> both +1.
REQ-038 trig[0] high through rst release -> count stays 0; fall then rise -> count 1; en=0 during a pulse -> no change.
REQ-039 NCH=3, WIDTH=4, MAX=9: sel=0..2 reads matching counts, sel=3 -> count_out=0; 10 events in mode=0 -> 9, ovf set.

Source files
------------

// File: rtl/sat_event_counter.sv
// rtl/sat_event_counter.sv - per-channel synchronized event counters with saturate/wrap and sticky overflow
module sat_event_counter #(
  parameter int NCH         = 4,
  parameter int WIDTH       = 2,
  parameter int MAX         = 2**WIDTH-1,
  parameter int SYNC_STAGES = 2,
  localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       trig,
  input  logic                 en,
  input  logic [NCH-1:0]       clr,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [NCH*WIDTH-1:0] counts,
  output logic [WIDTH-1:0]     count_out,
  output logic [NCH-1:0]       sat,
  output logic [NCH-1:0]       ovf,
  output logic                 any_ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  logic [SYNC_STAGES-1:0] r_sync [NCH];
  logic [NCH-1:0]         r_prev;
  logic [WIDTH-1:0]       r_cnt  [NCH];
  logic [NCH-1:0]         r_ovf;
  logic [NCH-1:0]         w_last;
  logic [NCH-1:0]         w_event;
  logic [WIDTH-1:0]       w_count_out;

  // Flops reset to 1 so a trig already high when rst releases is not seen as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_sync[i] <= '1;
      end
      r_prev <= '1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], trig[i]};
      end
      r_prev <= w_last;
    end
  end

  always_comb begin
    w_last = '0;
    for (int i = 0; i < NCH; i++) begin
      w_last[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  assign w_event = w_last & ~r_prev;

  // Clear wins over a same-cycle event; events while disabled are simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (en && w_event[i]) begin
          if (r_cnt[i] == MAX_W) begin
            r_ovf[i] <= 1'b1;
            if (mode) begin
              r_cnt[i] <= '0;
            end
          end else begin
            r_cnt[i] <= r_cnt[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  always_comb begin
    counts = '0;
    sat    = '0;
    for (int i = 0; i < NCH; i++) begin
      counts[i*WIDTH +: WIDTH] = r_cnt[i];
      sat[i]                   = (r_cnt[i] == MAX_W);
    end
  end

  // Select values with no matching channel fall through to 0.
  always_comb begin
    w_count_out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) begin
        w_count_out = r_cnt[i];
      end
    end
  end

  assign count_out = w_count_out;
  assign ovf       = r_ovf;
  assign any_ovf   = |r_ovf;

endmodule

// File: tb/tb_sat_event_counter.sv
// tb/tb_sat_event_counter.sv - randomized bench for sat_event_counter against a queue-based event model
module tb_sat_event_counter;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [3:0]  trig_a, clr_a;
  logic [1:0]  sel_a;
  logic [7:0]  counts_a;
  logic [1:0]  count_out_a;
  logic [3:0]  sat_a, ovf_a;
  logic        any_ovf_a;
  logic [2:0]  trig_b, clr_b;
  logic [1:0]  sel_b;
  logic [11:0] counts_b;
  logic [3:0]  count_out_b;
  logic [2:0]  sat_b, ovf_b;
  logic        any_ovf_b;

  int n_cmp = 0;
  int n_err = 0;

  int      m_cnt [2][4];
  bit      m_ovf [2][4];
  logic [7:0] tq [$];

  always #5 clk = ~clk;

  sat_event_counter dut_a (
    .clk(clk), .rst(rst), .trig(trig_a), .en(en), .clr(clr_a), .mode(mode), .sel(sel_a),
    .counts(counts_a), .count_out(count_out_a), .sat(sat_a), .ovf(ovf_a), .any_ovf(any_ovf_a)
  );

  sat_event_counter #(.NCH(3), .WIDTH(4), .MAX(9), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .rst(rst), .trig(trig_b), .en(en), .clr(clr_b), .mode(mode), .sel(sel_b),
    .counts(counts_b), .count_out(count_out_b), .sat(sat_b), .ovf(ovf_b), .any_ovf(any_ovf_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_ch(input int d, input int i, input bit ev, input bit c, input int mx);
    if (c) begin
      m_cnt[d][i] = 0;
      m_ovf[d][i] = 0;
    end else if (ev && en) begin
      if (m_cnt[d][i] == mx) begin
        m_ovf[d][i] = 1;
        if (mode) m_cnt[d][i] = 0;
      end else begin
        m_cnt[d][i] = m_cnt[d][i] + 1;
      end
    end
  endtask

  // An event counts at edge n when trig was sampled 1 at edge n-S and 0 at edge n-S-1.
  always @(posedge clk) begin
    logic [7:0] now_s, old_s;
    if (rst) begin
      tq.delete();
      repeat (S + 1) tq.push_back(8'hFF);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++) begin
          m_cnt[d][i] = 0;
          m_ovf[d][i] = 0;
        end
    end else begin
      now_s = tq[1];
      old_s = tq[0];
      for (int i = 0; i < 4; i++) model_ch(0, i, now_s[i] & ~old_s[i], clr_a[i], 3);
      for (int i = 0; i < 3; i++) model_ch(1, i, now_s[4+i] & ~old_s[4+i], clr_b[i], 9);
      tq.push_back({1'b0, trig_b, trig_a});
      void'(tq.pop_front());
    end
  end

  task automatic check_all();
    bit ao_a, ao_b;
    ao_a = 0;
    ao_b = 0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("a_cnt%0d", i), 32'(counts_a[i*2 +: 2]), 32'(m_cnt[0][i]));
      check_eq($sformatf("a_sat%0d", i), 32'(sat_a[i]), 32'(m_cnt[0][i] == 3));
      check_eq($sformatf("a_ovf%0d", i), 32'(ovf_a[i]), 32'(m_ovf[0][i]));
      ao_a |= m_ovf[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("b_cnt%0d", i), 32'(counts_b[i*4 +: 4]), 32'(m_cnt[1][i]));
      check_eq($sformatf("b_sat%0d", i), 32'(sat_b[i]), 32'(m_cnt[1][i] == 9));
      check_eq($sformatf("b_ovf%0d", i), 32'(ovf_b[i]), 32'(m_ovf[1][i]));
      ao_b |= m_ovf[1][i];
    end
    check_eq("a_any_ovf", 32'(any_ovf_a), 32'(ao_a));
    check_eq("b_any_ovf", 32'(any_ovf_b), 32'(ao_b));
    check_eq("a_count_out", 32'(count_out_a), 32'(m_cnt[0][sel_a]));
    check_eq("b_count_out", 32'(count_out_b), (sel_b < 2'd3) ? 32'(m_cnt[1][sel_b]) : 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b1;
    mode   = 1'b0;
    clr_a  = '0;
    clr_b  = '0;
    sel_a  = '0;
    sel_b  = '0;
    trig_a = 4'($urandom);
    trig_b = 3'($urandom);
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_all();
      if (rst && $urandom_range(1, 0) == 0) rst = 1'b0;
      en    = ($urandom_range(7, 0) != 0);
      if ($urandom_range(63, 0) == 0) mode = ~mode;
      for (int i = 0; i < 4; i++) clr_a[i] = ($urandom_range(127, 0) == 0);
      for (int i = 0; i < 3; i++) clr_b[i] = ($urandom_range(127, 0) == 0);
      sel_a = 2'($urandom);
      sel_b = 2'($urandom);
      #2;
      if (!rst && $urandom_range(399, 0) == 0) begin
        rst = 1'b1;
        #1;
        check_eq("async_rst_counts", {20'd0, counts_b, counts_a}, 32'd0);
        check_eq("async_rst_ovf", {25'd0, any_ovf_b, ovf_b, ovf_a}, 32'd0);
      end else begin
        #1;
      end
      #1;
      for (int i = 0; i < 4; i++) if ($urandom_range(3, 0) == 0) trig_a[i] = ~trig_a[i];
      for (int i = 0; i < 3; i++) if ($urandom_range(3, 0) == 0) trig_b[i] = ~trig_b[i];
    end
    @(negedge clk);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
